// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus the local word/handshake signals of spi_slave.
// The TXU flag exists only when SPI_SLAVE_STATUS_EN is defined.
interface spi_slave_if #(
    parameter int N = 8
);
    logic         SCLK;
    logic         CS;
    logic         MOSI;
    logic         MISO;
    logic         MISO_OE;
    logic [N-1:0] dataIN;
    logic         LOAD;
    logic [N-1:0] dataOUT;
    logic         DONE;
    logic         BUSY;
`ifdef SPI_SLAVE_STATUS_EN
    logic         TXU;
`endif

    modport slave (
        input  SCLK, CS, MOSI, dataIN, LOAD,
        output MISO, MISO_OE, dataOUT, DONE, BUSY
`ifdef SPI_SLAVE_STATUS_EN
        , output TXU
`endif
    );

    modport master (
        output SCLK, CS, MOSI, dataIN, LOAD,
        input  MISO, MISO_OE, dataOUT, DONE, BUSY
`ifdef SPI_SLAVE_STATUS_EN
        , input TXU
`endif
    );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: SPI mode 0 responder, MSB first, N-bit words, pins oversampled
// in the clk domain. Optional TX underrun flag under SPI_SLAVE_STATUS_EN.
module spi_slave #(
    parameter int N = 8
) (
    input  logic      clk,
    input  logic      reset,
    spi_slave_if.slave bus
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [2:0]    r_sclk_s;
    logic [2:0]    r_cs_s;
    logic [1:0]    r_mosi_s;
    logic [1:0]    r_arm_s;
    logic          r_armed;
    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_rx;
    logic [N-1:0]  r_tx;
    logic [N-1:0]  r_hold;
    logic [N-1:0]  r_dout;
    logic          r_done;

    logic          w_sclk_rise;
    logic          w_sclk_fall;
    logic          w_cs_fall;
    logic          w_cs_rise;
    logic          w_shift;
    logic          w_enter;
    logic          w_reload;
    logic          w_last;
    logic [N-1:0]  w_rx_next;
    logic [N-1:0]  w_tx_src;

    assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_s[2];
    assign w_sclk_fall = ~r_sclk_s[1] & r_sclk_s[2];
    assign w_cs_fall   = ~r_cs_s[1] & r_cs_s[2];
    assign w_cs_rise   = r_cs_s[1] & ~r_cs_s[2];
    assign w_shift     = (r_state == ST_SHIFT);
    assign w_enter     = ~w_shift & w_cs_fall & r_armed;
    assign w_reload    = w_enter | (w_shift & ~w_cs_rise & w_sclk_fall & (r_cnt == '0));
    assign w_last      = (r_cnt == CW'(N - 1));
    assign w_rx_next   = {r_rx[N-2:0], r_mosi_s[1]};
    // A LOAD coinciding with a reload bypasses the holding register
    assign w_tx_src    = bus.LOAD ? bus.dataIN : r_hold;

    // Two-flop synchronizers, third stage on SCLK/CS for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sclk_s <= '0;
            r_cs_s   <= '1;
            r_mosi_s <= '0;
        end else begin
            r_sclk_s <= {r_sclk_s[1:0], bus.SCLK};
            r_cs_s   <= {r_cs_s[1:0], bus.CS};
            r_mosi_s <= {r_mosi_s[0], bus.MOSI};
        end
    end

    // Accept a CS fall only after CS has been seen high through the flushed
    // synchronizer, so a frame interrupted by reset does not resume
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_arm_s <= '0;
            r_armed <= 1'b0;
        end else begin
            r_arm_s <= {r_arm_s[0], 1'b1};
            r_armed <= r_armed | (r_arm_s[1] & r_cs_s[1]);
        end
    end

    // TX holding register, written whenever LOAD is high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold <= '1;
        end else if (bus.LOAD) begin
            r_hold <= bus.dataIN;
        end
    end

    // Frame state machine with RX/TX shifting and word delivery
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rx    <= '0;
            r_tx    <= '1;
            r_dout  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_shift && w_cs_rise) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else if (w_enter) begin
                r_state <= ST_SHIFT;
                r_cnt   <= '0;
                r_tx    <= w_tx_src;
            end else if (w_shift) begin
                if (w_sclk_rise) begin
                    r_rx <= w_rx_next;
                    if (w_last) begin
                        r_cnt  <= '0;
                        r_dout <= w_rx_next;
                        r_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                if (w_sclk_fall) begin
                    if (r_cnt == '0) begin
                        r_tx <= w_tx_src;
                    end else begin
                        r_tx <= {r_tx[N-2:0], 1'b0};
                    end
                end
            end
        end
    end

`ifdef SPI_SLAVE_STATUS_EN
    logic r_loaded;
    logic r_txu;

    // Underrun tracking: flag a reload that finds no LOAD since the last one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_loaded <= 1'b0;
            r_txu    <= 1'b0;
        end else begin
            if (w_reload) begin
                r_loaded <= 1'b0;
            end else if (bus.LOAD) begin
                r_loaded <= 1'b1;
            end
            if (w_enter) begin
                r_txu <= ~(r_loaded | bus.LOAD);
            end else if (w_reload && !(r_loaded || bus.LOAD)) begin
                r_txu <= 1'b1;
            end
        end
    end

    assign bus.TXU = r_txu;
`endif

    assign bus.MISO    = w_shift ? r_tx[N-1] : 1'b1;
    assign bus.MISO_OE = w_shift;
    assign bus.BUSY    = w_shift;
    assign bus.dataOUT = r_dout;
    assign bus.DONE    = r_done;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed table of single-word frames plus hand-written
// two-word, abort and reset-mid-frame sequences for spi_slave (N=8).
module tb_spi_slave;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   done_cnt;

    spi_slave_if #(.N(8)) bus();

    spi_slave #(.N(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count DONE pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (bus.DONE) done_cnt <= done_cnt + 1;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: run did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit         ld_en;
        logic [7:0] ld_val;
        logic [7:0] mosi;
        logic [7:0] exp_rx;
        logic [7:0] exp_dout;
        logic       exp_txu;
        bit         chk_lat;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input logic [7:0] v);
        bus.dataIN = v;
        bus.LOAD   = 1'b1;
        wait_clk(1);
        bus.LOAD   = 1'b0;
    endtask

    // Master side of nbits SPI mode 0 bits at clk/8; MISO sampled at SCLK rise
    task automatic xfer(input logic [7:0] tx, input int nbits, input bit ld_en,
                        input logic [7:0] ld_val, input bit chk_lat,
                        output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            bus.MOSI = tx[7-i];
            if (ld_en && i == 2) begin
                pulse_load(ld_val);
                wait_clk(3);
            end else begin
                wait_clk(4);
            end
            bus.SCLK = 1'b1;
            rx = {rx[6:0], bus.MISO};
            if (chk_lat && i == 7) begin
                wait_clk(2);
                check("done_early", {31'd0, bus.DONE}, 32'd0);
                wait_clk(1);
                check("done_latency", {31'd0, bus.DONE}, 32'd1);
                wait_clk(1);
                check("done_width", {31'd0, bus.DONE}, 32'd0);
            end else begin
                wait_clk(4);
            end
            bus.SCLK = 1'b0;
        end
    endtask

    task automatic frame(input vec_t v, input int idx);
        logic [7:0] rx;
        int d0;
        d0 = done_cnt;
        if (v.ld_en) pulse_load(v.ld_val);
        bus.CS = 1'b0;
        wait_clk(4);
        check($sformatf("v%0d_busy", idx), {31'd0, bus.BUSY}, 32'd1);
`ifdef SPI_SLAVE_STATUS_EN
        check($sformatf("v%0d_txu", idx), {31'd0, bus.TXU}, {31'd0, v.exp_txu});
`endif
        xfer(v.mosi, 8, 1'b0, 8'h00, v.chk_lat, rx);
        wait_clk(4);
        bus.CS = 1'b1;
        wait_clk(6);
        check($sformatf("v%0d_miso_word", idx), {24'd0, rx}, {24'd0, v.exp_rx});
        check($sformatf("v%0d_dataOUT", idx), {24'd0, bus.dataOUT}, {24'd0, v.exp_dout});
        check($sformatf("v%0d_done_count", idx), done_cnt - d0, 32'd1);
        check($sformatf("v%0d_idle_oe", idx), {31'd0, bus.MISO_OE}, 32'd0);
    endtask

    initial begin
        logic [7:0] rx;
        int d0;
        n_tests  = 0;
        n_fail   = 0;
        done_cnt = 0;

        vecs[0] = '{1'b0, 8'h00, 8'h51, 8'hFF, 8'h51, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 8'h00, 8'hC3, 8'hA5, 8'hC3, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h80, 8'h01, 1'b0, 1'b0};

        // Reset with random inputs
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.SCLK   = 1'($urandom);
            bus.CS     = 1'($urandom);
            bus.MOSI   = 1'($urandom);
            bus.LOAD   = 1'($urandom);
            bus.dataIN = 8'($urandom);
            wait_clk(1);
        end
        check("rst_dataOUT", {24'd0, bus.dataOUT}, 32'd0);
        check("rst_DONE", {31'd0, bus.DONE}, 32'd0);
        check("rst_MISO", {31'd0, bus.MISO}, 32'd1);
        check("rst_MISO_OE", {31'd0, bus.MISO_OE}, 32'd0);
        check("rst_BUSY", {31'd0, bus.BUSY}, 32'd0);
`ifdef SPI_SLAVE_STATUS_EN
        check("rst_TXU", {31'd0, bus.TXU}, 32'd0);
`endif
        bus.SCLK = 1'b0;
        bus.CS   = 1'b1;
        bus.MOSI = 1'b0;
        bus.LOAD = 1'b0;
        wait_clk(2);
        reset = 1'b1;
        wait_clk(8);
        done_cnt = 0;

        for (int i = 0; i < 5; i++) frame(vecs[i], i);

        // Two-word frame with a LOAD during word 1
        d0 = done_cnt;
        pulse_load(8'h12);
        bus.CS = 1'b0;
        wait_clk(4);
        xfer(8'h40, 8, 1'b1, 8'h34, 1'b0, rx);
        check("w2_rx1", {24'd0, rx}, 32'h12);
        check("w2_dout1", {24'd0, bus.dataOUT}, 32'h40);
        xfer(8'h00, 8, 1'b0, 8'h00, 1'b0, rx);
        check("w2_rx2", {24'd0, rx}, 32'h34);
`ifdef SPI_SLAVE_STATUS_EN
        check("w2_txu", {31'd0, bus.TXU}, 32'd0);
`endif
        wait_clk(4);
        bus.CS = 1'b1;
        wait_clk(6);
        check("w2_dout2", {24'd0, bus.dataOUT}, 32'h00);
        check("w2_done_count", done_cnt - d0, 32'd2);

        // Abort after 5 SCLKs
        pulse_load(8'hFF);
        wait_clk(1);
        d0 = done_cnt;
        bus.CS = 1'b0;
        wait_clk(4);
        xfer(8'hAA, 5, 1'b0, 8'h00, 1'b0, rx);
        wait_clk(4);
        bus.CS = 1'b1;
        wait_clk(8);
        check("abort_no_done", done_cnt - d0, 32'd0);
        check("abort_dout_hold", {24'd0, bus.dataOUT}, 32'h00);
        check("abort_busy", {31'd0, bus.BUSY}, 32'd0);
        frame('{1'b1, 8'h5A, 8'h77, 8'h5A, 8'h77, 1'b0, 1'b0}, 5);

        // Reset mid-frame, released with CS still low
        pulse_load(8'h3E);
        d0 = done_cnt;
        bus.CS = 1'b0;
        wait_clk(4);
        xfer(8'hF0, 3, 1'b0, 8'h00, 1'b0, rx);
        check("rmf_rx_partial", {29'd0, rx[2:0]}, 32'd1);
        reset = 1'b0;
        #2;
        check("rmf_busy_in_reset", {31'd0, bus.BUSY}, 32'd0);
        check("rmf_miso_in_reset", {31'd0, bus.MISO}, 32'd1);
        check("rmf_dout_in_reset", {24'd0, bus.dataOUT}, 32'd0);
        wait_clk(2);
        reset = 1'b1;
        wait_clk(6);
        check("rmf_no_resume", {31'd0, bus.BUSY}, 32'd0);
        xfer(8'hF0, 5, 1'b0, 8'h00, 1'b0, rx);
        wait_clk(4);
        bus.CS = 1'b1;
        wait_clk(8);
        check("rmf_no_done", done_cnt - d0, 32'd0);
        check("rmf_dout", {24'd0, bus.dataOUT}, 32'd0);
        frame('{1'b0, 8'h00, 8'h9C, 8'hFF, 8'h9C, 1'b1, 1'b0}, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
